// File: rtl/instruction_fetch.sv
// Single-outstanding-request instruction fetch stage with a one-entry skid register.
// Optional delivered-instruction counter enabled by FETCH_COUNT_EN.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic        imemValid,
   input  logic [31:0] imemData,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirectPc,
   output logic [31:0] instruction,
   output logic [31:0] pc,
   output logic        valid
`ifdef FETCH_COUNT_EN
   ,
   output logic [31:0] fetchCount
`endif
);

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      FULL  = 2'd1,
      DRAIN = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic            req_q, req_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            valid_q, valid_d;
   logic [XLEN-1:0] skid_instr_q, skid_instr_d;
   logic [XLEN-1:0] skid_pc_q, skid_pc_d;

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= FETCH;
         fetch_pc_q   <= RESET_PC;
         addr_q       <= RESET_PC;
         req_q        <= 1'b0;
         instr_q      <= NOP;
         pc_q         <= '0;
         valid_q      <= 1'b0;
         skid_instr_q <= NOP;
         skid_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         addr_q       <= addr_d;
         req_q        <= req_d;
         instr_q      <= instr_d;
         pc_q         <= pc_d;
         valid_q      <= valid_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
      end
   end

   // Next-state logic; redirect overrides stall in every state
   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      req_d        = req_q;
      instr_d      = instr_q;
      pc_d         = pc_q;
      valid_d      = stall ? valid_q : 1'b0;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;

      if (redirect) begin
         valid_d    = 1'b0;
         fetch_pc_d = redirectPc & ~32'h0000_0003;
         req_d      = 1'b1;
         if (req_q && !imemValid) state_d = DRAIN;
         else                     state_d = FETCH;
      end else begin
         case (state_q)
            FETCH: begin
               req_d = 1'b1;
               if (req_q && imemValid) begin
                  fetch_pc_d = fetch_pc_q + 32'd4;
                  if (!valid_q || !stall) begin
                     instr_d = imemData;
                     pc_d    = fetch_pc_q;
                     valid_d = 1'b1;
                  end else begin
                     skid_instr_d = imemData;
                     skid_pc_d    = fetch_pc_q;
                     req_d        = 1'b0;
                     state_d      = FULL;
                  end
               end
            end
            FULL: begin
               if (!stall) begin
                  instr_d = skid_instr_q;
                  pc_d    = skid_pc_q;
                  valid_d = 1'b1;
                  req_d   = 1'b1;
                  state_d = FETCH;
               end
            end
            DRAIN: begin
               if (imemValid) state_d = FETCH;
            end
            default: state_d = FETCH;
         endcase
      end

      // The in-flight address must stay put while a stale response drains
      addr_d = (state_d == DRAIN) ? addr_q : fetch_pc_d;
   end

   assign imemReq     = req_q;
   assign imemAddr    = addr_q;
   assign instruction = instr_q;
   assign pc          = pc_q;
   assign valid       = valid_q;

`ifdef FETCH_COUNT_EN
   logic [XLEN-1:0] count_q;

   // Counts words accepted by the downstream stage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) count_q <= '0;
      else if (valid_q && !stall && !redirect) count_q <= count_q + 32'd1;
   end

   assign fetchCount = count_q;
`endif

endmodule
